// File: rtl/dmem_load_store_unit.sv
// Load/store initiator for a word-wide, byte-addressed, big-endian data memory.
// One request in flight; SB/SH are performed as read-modify-write since the memory has no byte strobes.
module dmem_load_store_unit #(
   parameter int N         = 32,
   parameter int MEM_BYTES = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_write,
   input  logic [2:0]   req_funct3,
   input  logic [N-1:0] req_addr,
   input  logic [N-1:0] req_wdata,
   output logic         resp_valid,
   output logic [N-1:0] resp_rdata,
   output logic         resp_error,
   output logic [N-1:0] mem_addr,
   output logic         mem_write_enable,
   output logic [N-1:0] mem_write_data,
   input  logic [N-1:0] mem_read_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_STORE, S_RMW_READ, S_RMW_WRITE, S_RESP
   } state_t;

   localparam logic [N-1:0] MEM_LIMIT = N'(MEM_BYTES);

   state_t       r_state, w_state_next;
   logic [N-1:0] r_addr, r_wdata, r_merge, r_rdata;
   logic [1:0]   r_lane;
   logic [2:0]   r_funct3;
   logic         r_error;

   logic         w_accept, w_illegal, w_misaligned, w_range, w_err, w_writing;
   logic [7:0]   w_byte;
   logic [15:0]  w_half;
   logic [N-1:0] w_load_ext, w_merge;

   assign w_accept = req_valid && (r_state == S_IDLE);

   always_comb begin
      w_illegal = 1'b0;
      if (req_write)
         w_illegal = (req_funct3 > 3'd2);
      else
         w_illegal = !(req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      w_misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
      w_range      = (req_addr >= MEM_LIMIT);
   end

   assign w_err = w_illegal || w_misaligned || w_range;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_err)
                  w_state_next = S_RESP;
               else if (!req_write)
                  w_state_next = S_LOAD;
               else if (req_funct3[1:0] == 2'd2)
                  w_state_next = S_STORE;
               else
                  w_state_next = S_RMW_READ;
            end
         end
         S_LOAD, S_STORE, S_RMW_WRITE: w_state_next = S_RESP;
         S_RMW_READ:                   w_state_next = S_RMW_WRITE;
         S_RESP:                       w_state_next = S_IDLE;
         default:                      w_state_next = S_IDLE;
      endcase
   end

   // Lane 0 is the most significant byte of the word.
   always_comb begin
      case (r_lane)
         2'd0:    w_byte = mem_read_data[N-1:N-8];
         2'd1:    w_byte = mem_read_data[N-9:N-16];
         2'd2:    w_byte = mem_read_data[N-17:N-24];
         default: w_byte = mem_read_data[N-25:N-32];
      endcase
      w_half = r_lane[1] ? mem_read_data[N-17:N-32] : mem_read_data[N-1:N-16];
      case (r_funct3)
         3'd0:    w_load_ext = {{(N-8){w_byte[7]}}, w_byte};
         3'd1:    w_load_ext = {{(N-16){w_half[15]}}, w_half};
         3'd2:    w_load_ext = mem_read_data;
         3'd4:    w_load_ext = {{(N-8){1'b0}}, w_byte};
         3'd5:    w_load_ext = {{(N-16){1'b0}}, w_half};
         default: w_load_ext = '0;
      endcase
   end

   // Byte-lane merge for SB/SH: a halfword occupies lanes r_lane (high byte) and r_lane+1.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic w_hit_b, w_hit_hi, w_hit_lo;
      assign w_hit_b  = (r_funct3[1:0] == 2'd0) && (r_lane == LANE);
      assign w_hit_hi = (r_funct3[1:0] == 2'd1) && (r_lane == LANE);
      assign w_hit_lo = (r_funct3[1:0] == 2'd1) && ((r_lane + 2'd1) == LANE);
      assign w_merge[N-1-8*gi -: 8] = w_hit_b  ? r_wdata[7:0]  :
                                      w_hit_hi ? r_wdata[15:8] :
                                      w_hit_lo ? r_wdata[7:0]  :
                                                 r_merge[N-1-8*gi -: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_lane   <= '0;
         r_funct3 <= '0;
         r_wdata  <= '0;
         r_merge  <= '0;
         r_rdata  <= '0;
         r_error  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr   <= {req_addr[N-1:2], 2'b00};
                  r_lane   <= req_addr[1:0];
                  r_funct3 <= req_funct3;
                  r_wdata  <= req_wdata;
                  if (w_err) begin
                     r_rdata <= '0;
                     r_error <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               r_rdata <= w_load_ext;
               r_error <= 1'b0;
            end
            S_STORE, S_RMW_WRITE: begin
               r_rdata <= '0;
               r_error <= 1'b0;
            end
            S_RMW_READ: r_merge <= mem_read_data;
            default: ;
         endcase
      end
   end

   // Reset overrides the strobe in the same cycle so an aborted RMW never writes.
   assign w_writing        = ((r_state == S_STORE) || (r_state == S_RMW_WRITE)) && !rst;
   assign mem_write_enable = w_writing;
   assign mem_write_data   = !w_writing ? '0 : ((r_state == S_STORE) ? r_wdata : w_merge);
   assign mem_addr         = r_addr;
   assign req_ready        = (r_state == S_IDLE);
   assign resp_valid       = (r_state == S_RESP);
   assign resp_rdata       = r_rdata;
   assign resp_error       = r_error;

endmodule

// File: tb/tb_dmem_load_store_unit.sv
// Directed bench for dmem_load_store_unit: table of single requests against a small
// word memory model, plus reset-abort and back-to-back sequences.
module tb_dmem_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_error;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic        mem_write_enable;

   logic [31:0] mem [0:63];
   int          wr_total = 0;
   logic [31:0] wr_addr  = '0;
   logic        bd_we = 1'b0;
   logic [5:0]  bd_idx = '0;
   logic [31:0] bd_data = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_load_store_unit #(.N(32), .MEM_BYTES(256)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
      .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   assign mem_read_data = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_data;
      if (mem_write_enable) begin
         mem[mem_addr[7:2]] <= mem_write_data;
         wr_total <= wr_total + 1;
         wr_addr  <= mem_addr;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bd_write(input logic [5:0] idx, input logic [31:0] data);
      @(negedge clk);
      bd_we = 1'b1; bd_idx = idx; bd_data = data;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output int nwr, output logic [31:0] waddr);
      int w0;
      int guard;
      @(negedge clk);
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
      w0 = wr_total;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 20);
      rd = resp_rdata; er = resp_error; nwr = wr_total - w0; waddr = wr_addr;
   endtask

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_wr;
   } vec_t;

   vec_t vecs [21];

   initial begin
      int          lat, nwr, w0, cyc, idx, nresp, busy_ready, extra;
      logic [31:0] rd, waddr;
      logic        er, acc;
      logic        b_wr   [6];
      logic [31:0] b_addr [6];
      logic [31:0] b_wd   [6];
      logic [31:0] b_exp  [6];

      vecs[0]  = '{1'b0, 3'd0, 32'h11,  32'h0,        32'hFFFFFF99, 1'b0, 2, 0};
      vecs[1]  = '{1'b0, 3'd4, 32'h13,  32'h0,        32'h000000BB, 1'b0, 2, 0};
      vecs[2]  = '{1'b0, 3'd5, 32'h12,  32'h0,        32'h0000AABB, 1'b0, 2, 0};
      vecs[3]  = '{1'b0, 3'd1, 32'h10,  32'h0,        32'hFFFF8899, 1'b0, 2, 0};
      vecs[4]  = '{1'b0, 3'd4, 32'h10,  32'h0,        32'h00000088, 1'b0, 2, 0};
      vecs[5]  = '{1'b0, 3'd1, 32'h12,  32'h0,        32'hFFFFAABB, 1'b0, 2, 0};
      vecs[6]  = '{1'b1, 3'd2, 32'h20,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
      vecs[7]  = '{1'b0, 3'd2, 32'h20,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
      vecs[8]  = '{1'b1, 3'd0, 32'h21,  32'h12345677, 32'h0,        1'b0, 3, 1};
      vecs[9]  = '{1'b0, 3'd2, 32'h20,  32'h0,        32'hDE77BEEF, 1'b0, 2, 0};
      vecs[10] = '{1'b1, 3'd1, 32'h22,  32'h0000CAFE, 32'h0,        1'b0, 3, 1};
      vecs[11] = '{1'b0, 3'd2, 32'h20,  32'h0,        32'hDE77CAFE, 1'b0, 2, 0};
      vecs[12] = '{1'b1, 3'd0, 32'h23,  32'h000000A5, 32'h0,        1'b0, 3, 1};
      vecs[13] = '{1'b0, 3'd2, 32'h20,  32'h0,        32'hDE77CAA5, 1'b0, 2, 0};
      vecs[14] = '{1'b0, 3'd2, 32'h22,  32'h0,        32'h0,        1'b1, 1, 0};
      vecs[15] = '{1'b1, 3'd1, 32'h23,  32'h0000FFFF, 32'h0,        1'b1, 1, 0};
      vecs[16] = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0};
      vecs[17] = '{1'b0, 3'd3, 32'h10,  32'h0,        32'h0,        1'b1, 1, 0};
      vecs[18] = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h8899AABB, 1'b0, 2, 0};
      vecs[19] = '{1'b1, 3'd4, 32'h20,  32'h0,        32'h0,        1'b1, 1, 0};
      vecs[20] = '{1'b0, 3'd1, 32'h11,  32'h0,        32'h0,        1'b1, 1, 0};

      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_ready",  {31'b0, req_ready},        32'h1);
      chk("reset_resp",   {31'b0, resp_valid},       32'h0);
      chk("reset_err",    {31'b0, resp_error},       32'h0);
      chk("reset_rdata",  resp_rdata,                32'h0);
      chk("reset_we",     {31'b0, mem_write_enable}, 32'h0);
      chk("reset_maddr",  mem_addr,                  32'h0);
      chk("reset_mwdata", mem_write_data,            32'h0);
      rst = 1'b0;

      bd_write(6'd4,  32'h8899AABB);
      bd_write(6'd8,  32'h00000000);
      bd_write(6'd12, 32'h11223344);

      for (int i = 0; i < 21; i++) begin
         do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, er, nwr, waddr);
         $display("txn %0d wr=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d writes=%0d",
                  i, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, nwr);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
         chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_writes", i), nwr, vecs[i].exp_wr);
         if (vecs[i].exp_wr > 0)
            chk($sformatf("v%0d_waddr", i), waddr, {vecs[i].addr[31:2], 2'b00});
      end

      // Reset while in RMW_READ: the SB must be abandoned without touching memory.
      w0 = wr_total;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h30; req_wdata = 32'hFF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      $display("txn rst_in_rmw_read ready=%0d resp=%0d err=%0d writes=%0d",
               req_ready, resp_valid, resp_error, wr_total - w0);
      chk("rstrd_ready", {31'b0, req_ready},  32'h1);
      chk("rstrd_resp",  {31'b0, resp_valid}, 32'h0);
      chk("rstrd_err",   {31'b0, resp_error}, 32'h0);
      chk("rstrd_maddr", mem_addr,            32'h0);
      repeat (3) @(negedge clk);
      chk("rstrd_writes", wr_total - w0, 32'h0);
      chk("rstrd_word",   mem[12],       32'h11223344);

      // Reset while in RMW_WRITE: the strobe of that very cycle must be suppressed.
      w0 = wr_total;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1; req_addr = 32'h32; req_wdata = 32'hBEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rstwr_we", {31'b0, mem_write_enable}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      $display("txn rst_in_rmw_write ready=%0d writes=%0d word=%h",
               req_ready, wr_total - w0, mem[12]);
      chk("rstwr_ready",  {31'b0, req_ready}, 32'h1);
      chk("rstwr_writes", wr_total - w0,      32'h0);
      chk("rstwr_word",   mem[12],            32'h11223344);

      // req_valid held high with alternating SW/LW.
      b_wr[0] = 1'b1; b_addr[0] = 32'h40; b_wd[0] = 32'h11110001; b_exp[0] = 32'h0;
      b_wr[1] = 1'b0; b_addr[1] = 32'h40; b_wd[1] = 32'h0;        b_exp[1] = 32'h11110001;
      b_wr[2] = 1'b1; b_addr[2] = 32'h44; b_wd[2] = 32'h22220002; b_exp[2] = 32'h0;
      b_wr[3] = 1'b0; b_addr[3] = 32'h44; b_wd[3] = 32'h0;        b_exp[3] = 32'h22220002;
      b_wr[4] = 1'b1; b_addr[4] = 32'h40; b_wd[4] = 32'h33330003; b_exp[4] = 32'h0;
      b_wr[5] = 1'b0; b_addr[5] = 32'h40; b_wd[5] = 32'h0;        b_exp[5] = 32'h33330003;
      w0 = wr_total; idx = 0; nresp = 0; busy_ready = 0; cyc = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = b_wr[0]; req_funct3 = 3'd2;
      req_addr = b_addr[0]; req_wdata = b_wd[0];
      while (nresp < 6 && cyc < 100) begin
         if (idx > nresp && req_ready) busy_ready++;
         if (resp_valid && nresp < 6) begin
            $display("txn b2b %0d rdata=%h err=%0d", nresp, resp_rdata, resp_error);
            chk($sformatf("b2b%0d_rdata", nresp), resp_rdata, b_exp[nresp]);
            chk($sformatf("b2b%0d_err", nresp), {31'b0, resp_error}, 32'h0);
            nresp++;
         end
         acc = req_ready && req_valid;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 6) begin
               req_write = b_wr[idx]; req_addr = b_addr[idx]; req_wdata = b_wd[idx];
            end else begin
               req_valid = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid) extra++;
      end
      chk("b2b_accepts",    idx,           32'd6);
      chk("b2b_responses",  nresp,         32'd6);
      chk("b2b_extra_resp", extra,         32'd0);
      chk("b2b_ready_busy", busy_ready,    32'd0);
      chk("b2b_writes",     wr_total - w0, 32'd3);
      chk("b2b_word40",     mem[16],       32'h33330003);
      chk("b2b_word44",     mem[17],       32'h22220002);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_load_store_unit.md
Name: dmem_load_store_unit

Overview:
- Initiator side of the data-memory port: accepts one load/store request at a time from the core pipeline and drives the word-wide, byte-addressed data memory.
- The memory has a combinational read and a full-word-only synchronous write with no byte strobes, so the block performs read-modify-write for SB/SH.
- It also performs sign/zero extension for loads and flags misaligned, out-of-range and illegal accesses.
- Sits between the execute stage and the data memory.

Parameters:
N, 32, data/address width
MEM_BYTES, 256, memory size in bytes (SIZE*BYTE_WIDTH of the data memory); power of two

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2
req_addr  in  N  byte address
req_wdata  in  N  store data (low bits used for SB/SH)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  N  extended load data; 0 for stores and errors
resp_error  out  1  valid with resp_valid: misaligned, out of range, or illegal funct3
mem_addr  out  N  word-aligned address to data memory
mem_write_enable  out  1  data memory write strobe
mem_write_data  out  N  data memory write word
mem_read_data  in  N  data memory combinational read word

Behaviour:
- Only clk and rst are clocked/reset inputs; single clock domain. Reset is synchronous and active-high.
- Memory byte order: the word at aligned address A is {byte[A], byte[A+1], byte[A+2], byte[A+3]}, so lane 0 (addr[1:0]=0) is bits [31:24] and lane 3 is bits [7:0].
- Halfword at lane 0 is [31:16]; at lane 2 it is [15:0].
- mem_addr = {req_addr[N-1:2], 2'b00}, captured at acceptance; held constant while busy.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_write_enable=0, mem_addr=0, mem_write_data=0.
- Handshake: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE. Inputs are captured into internal registers at acceptance.
- Error check at acceptance, and the first matching condition wins:
  - illegal funct3: load not in {0,1,2,4,5}, store not in {0,1,2};
  - misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0;
  - out of range: req_addr >= MEM_BYTES.
  - On any error: no memory write and no read is used; the block goes to RESP with resp_error=1 and resp_rdata=0.
- FSM states: IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP.
  - IDLE -> RESP on error.
  - IDLE -> LOAD for a valid load.
  - IDLE -> STORE for a valid SW.
  - IDLE -> RMW_READ for a valid SB/SH.
  - LOAD: sample mem_read_data, select lane, sign-extend (LB/LH) or zero-extend (LBU/LHU) into resp_rdata -> RESP.
  - STORE: mem_write_enable=1 for exactly this cycle, mem_write_data=wdata -> RESP.
  - RMW_READ: latch mem_read_data into merge register -> RMW_WRITE.
  - RMW_WRITE: mem_write_enable=1 for one cycle. mem_write_data = latched word with the target lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH); other bytes unchanged -> RESP.
  - RESP: resp_valid=1 for one cycle -> IDLE, where req_ready=1 on the next cycle.
- Latency from the acceptance edge to the resp_valid-high cycle:
  - load and SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- Throughput is one request in flight. Back-to-back requests are accepted every 3 or 4 cycles.
- mem_write_enable is never high outside STORE/RMW_WRITE. mem_write_data is 0 when not writing.
- resp_rdata/resp_error hold their value until the next RESP. resp_error clears on the next non-error response.
- Reset mid-operation, in any state: next cycle is IDLE with all outputs at reset values.
  - An in-progress RMW aborts with no write if reset is asserted in RMW_READ.
  - If reset is asserted in RMW_WRITE, the write strobe for that cycle is suppressed because reset has priority.
- req_valid while busy is ignored, not queued. The requester must hold req_valid until req_ready.

Test Plan:
- Reset, then memory word at 0x10 = 0x8899AABB. Request LB @0x11 -> resp after 2 cycles, resp_rdata=0xFFFFFF99, error=0. Request LBU @0x13 -> 0x000000BB. Request LHU @0x12 -> 0x0000AABB.
- SW 0xDEADBEEF @0x20 -> single mem_write_enable pulse, mem_addr=0x20, data=0xDEADBEEF. A following LW @0x20 -> 0xDEADBEEF.
- Word 0x20 = 0xDEADBEEF. SB wdata=0x12345677 @0x21 -> RMW write of 0xDE77BEEF, resp at cycle 3. SH wdata=0x0000CAFE @0x22 -> word becomes 0xDE77CAFE.
- LW @0x22, SH @0x23, req_addr=MEM_BYTES (0x100), and load funct3=3 -> each gives resp_error=1 one cycle after acceptance, resp_rdata=0, no mem_write_enable pulse.
- Assert rst during RMW_READ of SB @0x30 (word 0x11223344) -> no write occurs, word remains 0x11223344, req_ready=1 the cycle after reset.
- Hold req_valid continuously with alternating LW/SW requests -> req_ready low while busy, each request accepted exactly once, and responses occur in request order.
